elevator_ctrl_n: RTL and testbench

- Parametrised successor of the fixed 8-floor elevator status machine.
- Single controller for N floors: latches hall and car requests, schedules with collective (SCAN) logic, and runs move and door timers off a tick enable.
- Sits between the input-processor request vectors and the display block.
- Adds behaviour the 8-floor machine lacks: configurable floor count and timing, direction-preserving scheduling, and door-hold/door-close buttons.

---
 rtl/elevator_ctrl_n_pkg.sv | 18 +
 rtl/elevator_ctrl_n_if.sv | 32 +++
 rtl/elevator_ctrl_n_req_bank.sv | 80 ++++++++
 rtl/elevator_ctrl_n.sv | 193 +++++++++++++++++++
 tb/tb_elevator_ctrl_n.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/elevator_ctrl_n_pkg.sv
// rtl/elevator_ctrl_n_pkg.sv - shared state encoding and direction constants for the elevator controller
package elevator_ctrl_n_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_MOVING = 2'd1,
    ST_OPEN   = 2'd2
  } state_t;

  localparam logic UP   = 1'b1;
  localparam logic DOWN = 1'b0;

  // Select the value belonging to the given direction (up_val when travelling up).
  function automatic logic pick_dir(input logic dir, input logic up_val, input logic down_val);
    return (dir == DOWN) ? down_val : up_val;
  endfunction

endpackage

// File: rtl/elevator_ctrl_n_if.sv
// rtl/elevator_ctrl_n_if.sv - request inputs and status outputs of the elevator controller
interface elevator_ctrl_n_if #(
  parameter int FLOORS = 8,
  parameter int FW     = $clog2(FLOORS),
  parameter int CW     = 2
);
  logic              tick;
  logic [FLOORS-1:0] up_call;
  logic [FLOORS-1:0] down_call;
  logic [FLOORS-1:0] car_call;
  logic              door_open_btn;
  logic              door_close_btn;

  logic [FW-1:0]     floor;
  logic [CW-1:0]     countdown;
  logic              dir_up;
  logic              moving;
  logic              door_open;
  logic [FLOORS-1:0] pend_up;
  logic [FLOORS-1:0] pend_down;
  logic [FLOORS-1:0] pend_car;

  modport master (
    output tick, up_call, down_call, car_call, door_open_btn, door_close_btn,
    input  floor, countdown, dir_up, moving, door_open, pend_up, pend_down, pend_car
  );

  modport slave (
    input  tick, up_call, down_call, car_call, door_open_btn, door_close_btn,
    output floor, countdown, dir_up, moving, door_open, pend_up, pend_down, pend_car
  );
endinterface

// File: rtl/elevator_ctrl_n_req_bank.sv
// rtl/elevator_ctrl_n_req_bank.sv - pending request registers with end-floor masking and floor-relative reductions
module elevator_ctrl_n_req_bank #(
  parameter int FLOORS = 8,
  parameter int FW     = $clog2(FLOORS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [FLOORS-1:0] up_call,
  input  logic [FLOORS-1:0] down_call,
  input  logic [FLOORS-1:0] car_call,
  input  logic [FW-1:0]     at_floor,
  input  logic              clr_up,
  input  logic              clr_down,
  input  logic              clr_car,
  output logic [FLOORS-1:0] pend_up,
  output logic [FLOORS-1:0] pend_down,
  output logic [FLOORS-1:0] pend_car,
  output logic              req_above,
  output logic              req_below,
  output logic              req_here,
  output logic              up_here,
  output logic              down_here,
  output logic              car_here,
  output logic              up_in_here,
  output logic              down_in_here,
  output logic              car_in_here
);

  logic [FLOORS-1:0] up_m;
  logic [FLOORS-1:0] down_m;
  logic [FLOORS-1:0] here_oh;
  logic [FLOORS-1:0] above_m;
  logic [FLOORS-1:0] below_m;
  logic [FLOORS-1:0] any_pend;

  // No up call exists at the top floor and no down call at the bottom floor.
  always_comb begin
    up_m             = up_call;
    up_m[FLOORS-1]   = 1'b0;
    down_m           = down_call;
    down_m[0]        = 1'b0;
  end

  // Floor masks relative to the floor the controller is evaluating this clk.
  always_comb begin
    here_oh = '0;
    above_m = '0;
    below_m = '0;
    for (int i = 0; i < FLOORS; i++) begin
      here_oh[i] = (i == int'(at_floor));
      above_m[i] = (i > int'(at_floor));
      below_m[i] = (i < int'(at_floor));
    end
  end

  assign any_pend     = pend_up | pend_down | pend_car;
  assign req_above    = |(any_pend & above_m);
  assign req_below    = |(any_pend & below_m);
  assign req_here     = |(any_pend & here_oh);
  assign up_here      = |(pend_up & here_oh);
  assign down_here    = |(pend_down & here_oh);
  assign car_here     = |(pend_car & here_oh);
  assign up_in_here   = |(up_m & here_oh);
  assign down_in_here = |(down_m & here_oh);
  assign car_in_here  = |(car_call & here_oh);

  // Accumulate requests; a clear at at_floor beats a new press there in the same clk.
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_up   <= '0;
      pend_down <= '0;
      pend_car  <= '0;
    end else begin
      pend_up   <= (pend_up   | up_m)     & ~(here_oh & {FLOORS{clr_up}});
      pend_down <= (pend_down | down_m)   & ~(here_oh & {FLOORS{clr_down}});
      pend_car  <= (pend_car  | car_call) & ~(here_oh & {FLOORS{clr_car}});
    end
  end

endmodule

// File: rtl/elevator_ctrl_n.sv
// rtl/elevator_ctrl_n.sv - N-floor collective (SCAN) elevator controller with tick-driven move and door timers
module elevator_ctrl_n #(
  parameter int FLOORS     = 8,
  parameter int MOVE_TICKS = 2,
  parameter int DOOR_TICKS = 3,
  parameter int FW         = $clog2(FLOORS),
  parameter int CW         = $clog2(((MOVE_TICKS > DOOR_TICKS) ? MOVE_TICKS : DOOR_TICKS) + 1)
) (
  input logic              clk,
  input logic              rst,
  elevator_ctrl_n_if.slave bus
);
  import elevator_ctrl_n_pkg::*;

  localparam logic [FW-1:0] TOP_FLOOR = FW'(FLOORS - 1);
  localparam logic [CW-1:0] MOVE_LD   = CW'(MOVE_TICKS);
  localparam logic [CW-1:0] DOOR_LD   = CW'(DOOR_TICKS);

  state_t        state_q, state_n;
  logic [FW-1:0] floor_q, floor_n, floor_c;
  logic          dir_q, dir_n;
  logic [CW-1:0] cd_q, cd_n;

  logic step;
  logic enter_open;
  logic clr_up, clr_down, clr_car;

  logic req_above, req_below, req_here;
  logic up_here, down_here, car_here;
  logic up_in_here, down_in_here, car_in_here;
  logic [FLOORS-1:0] pend_up, pend_down, pend_car;

  logic beyond, behind, hall_dir_here, hall_dir_in, at_end, stop, flip, reload;

  elevator_ctrl_n_req_bank #(
    .FLOORS (FLOORS),
    .FW     (FW)
  ) u_req_bank (
    .clk          (clk),
    .rst          (rst),
    .up_call      (bus.up_call),
    .down_call    (bus.down_call),
    .car_call     (bus.car_call),
    .at_floor     (floor_c),
    .clr_up       (clr_up),
    .clr_down     (clr_down),
    .clr_car      (clr_car),
    .pend_up      (pend_up),
    .pend_down    (pend_down),
    .pend_car     (pend_car),
    .req_above    (req_above),
    .req_below    (req_below),
    .req_here     (req_here),
    .up_here      (up_here),
    .down_here    (down_here),
    .car_here     (car_here),
    .up_in_here   (up_in_here),
    .down_in_here (down_in_here),
    .car_in_here  (car_in_here)
  );

  // Floor the car occupies after this clk; the bank evaluates requests against it
  // so the stop check on arrival sees the new floor in the same clk.
  always_comb begin
    floor_c = floor_q;
    step    = (state_q == ST_MOVING) && bus.tick && (cd_q <= CW'(1));
    if (step) begin
      if (dir_q == UP && floor_q != TOP_FLOOR) begin
        floor_c = floor_q + FW'(1);
      end else if (dir_q != UP && floor_q != '0) begin
        floor_c = floor_q - FW'(1);
      end
    end
  end

  assign beyond        = pick_dir(dir_q, req_above, req_below);
  assign behind        = pick_dir(dir_q, req_below, req_above);
  assign hall_dir_here = pick_dir(dir_q, up_here, down_here);
  assign hall_dir_in   = pick_dir(dir_q, up_in_here, down_in_here);
  assign at_end        = pick_dir(dir_q, floor_c == TOP_FLOOR, floor_c == '0);
  assign stop          = car_here | hall_dir_here | (!beyond & req_here) | at_end;
  // Turn around when nothing lies ahead, or when the only reason to open here is
  // a hall call in the opposite direction (otherwise IDLE would reopen forever).
  assign flip          = !beyond | (!car_here & !hall_dir_here);
  assign reload        = car_in_here | hall_dir_in;

  // Next-state, timer, direction and request-clear decisions.
  always_comb begin
    state_n    = state_q;
    floor_n    = floor_q;
    dir_n      = dir_q;
    cd_n       = cd_q;
    clr_up     = 1'b0;
    clr_down   = 1'b0;
    clr_car    = 1'b0;
    enter_open = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (req_here) begin
          enter_open = 1'b1;
          state_n    = ST_OPEN;
          cd_n       = DOOR_LD;
        end else if (beyond) begin
          state_n = ST_MOVING;
          cd_n    = MOVE_LD;
        end else if (behind) begin
          dir_n   = ~dir_q;
          state_n = ST_MOVING;
          cd_n    = MOVE_LD;
        end else begin
          cd_n = '0;
        end
      end

      ST_MOVING: begin
        if (bus.tick) begin
          if (step) begin
            floor_n = floor_c;
            if (stop) begin
              enter_open = 1'b1;
              state_n    = ST_OPEN;
              cd_n       = DOOR_LD;
            end else begin
              cd_n = MOVE_LD;
            end
          end else begin
            cd_n = cd_q - CW'(1);
          end
        end
      end

      ST_OPEN: begin
        // Presses being served at this floor are swallowed instead of latched.
        clr_car = 1'b1;
        if (dir_q == UP) clr_up = 1'b1;
        else             clr_down = 1'b1;

        if (bus.door_open_btn || reload) begin
          cd_n = DOOR_LD;
        end else if (cd_q == '0) begin
          state_n = ST_IDLE;
        end else if (bus.door_close_btn) begin
          cd_n = '0;
        end else if (bus.tick) begin
          cd_n = cd_q - CW'(1);
        end
      end

      default: begin
        state_n = ST_IDLE;
        cd_n    = '0;
      end
    endcase

    if (enter_open) begin
      clr_car = 1'b1;
      if (dir_q == UP) begin
        clr_up   = 1'b1;
        clr_down = flip;
      end else begin
        clr_down = 1'b1;
        clr_up   = flip;
      end
      if (flip) dir_n = ~dir_q;
    end
  end

  // Controller state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_IDLE;
      floor_q <= '0;
      dir_q   <= UP;
      cd_q    <= '0;
    end else begin
      state_q <= state_n;
      floor_q <= floor_n;
      dir_q   <= dir_n;
      cd_q    <= cd_n;
    end
  end

  assign bus.floor     = floor_q;
  assign bus.countdown = cd_q;
  assign bus.dir_up    = dir_q;
  assign bus.moving    = (state_q == ST_MOVING);
  assign bus.door_open = (state_q == ST_OPEN);
  assign bus.pend_up   = pend_up;
  assign bus.pend_down = pend_down;
  assign bus.pend_car  = pend_car;

endmodule

// File: tb/tb_elevator_ctrl_n.sv
// tb/tb_elevator_ctrl_n.sv - directed vector and sequence bench for elevator_ctrl_n (8 floors, 2 move ticks, 3 door ticks)
module tb_elevator_ctrl_n;

  localparam int FLOORS = 8;
  localparam int FW     = 3;
  localparam int CW     = 2;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  elevator_ctrl_n_if #(.FLOORS(FLOORS), .FW(FW), .CW(CW)) bus ();

  elevator_ctrl_n #(
    .FLOORS     (FLOORS),
    .MOVE_TICKS (2),
    .DOOR_TICKS (3),
    .FW         (FW),
    .CW         (CW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    logic       rst;
    logic       tick;
    logic [7:0] up;
    logic [7:0] dn;
    logic [7:0] car;
    logic       obtn;
    logic       cbtn;
    logic [31:0] exp;
  } vec_t;

  vec_t vecs[$];
  int   tests = 0;
  int   fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] obs();
    return {bus.floor, bus.countdown, bus.dir_up, bus.moving, bus.door_open,
            bus.pend_up, bus.pend_down, bus.pend_car};
  endfunction

  task automatic add(input logic r, input logic t, input logic [7:0] up, input logic [7:0] dn,
                     input logic [7:0] car, input logic ob, input logic cb,
                     input logic [2:0] fl, input logic [1:0] cd, input logic dir,
                     input logic mv, input logic dop,
                     input logic [7:0] pu, input logic [7:0] pd, input logic [7:0] pc);
    vec_t v;
    v.rst = r; v.tick = t; v.up = up; v.dn = dn; v.car = car; v.obtn = ob; v.cbtn = cb;
    v.exp = {fl, cd, dir, mv, dop, pu, pd, pc};
    vecs.push_back(v);
  endtask

  task automatic clear_inputs();
    bus.tick           = 1'b0;
    bus.up_call        = '0;
    bus.down_call      = '0;
    bus.car_call       = '0;
    bus.door_open_btn  = 1'b0;
    bus.door_close_btn = 1'b0;
  endtask

  // One clk with the currently driven inputs; pulses are dropped afterwards.
  task automatic cyc(input logic t);
    bus.tick = t;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cyc(1'b0);
    rst = 1'b0;
  endtask

  task automatic run_to_open(input int max, output bit ok, output bit saw_down);
    ok = 1'b0;
    saw_down = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      cyc(i[0]);
      if (bus.door_open) ok = 1'b1;
      else if (bus.moving && !bus.dir_up) saw_down = 1'b1;
    end
  endtask

  task automatic run_to_closed(input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      cyc(i[0]);
      if (!bus.door_open) ok = 1'b1;
    end
  endtask

  task automatic run_to_floor(input logic [2:0] f, input int max, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < max && !ok; i++) begin
      cyc(i[0]);
      if (bus.moving && bus.floor == f) ok = 1'b1;
    end
  endtask

  initial begin
    bit ok;
    bit sd;

    rst = 1'b1;
    clear_inputs();

    // Car call to floor 3 from reset, then end-floor hall calls that must be ignored.
    //  r  t  up     dn     car    ob cb  fl cd dir mv do  pu     pd     pc
    add(1, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 0, 8'h00, 8'h00, 8'h08, 0, 0, 0, 0, 1, 0, 0, 8'h00, 8'h00, 8'h08);
    add(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 0, 2, 1, 1, 0, 8'h00, 8'h00, 8'h08);
    add(0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 0, 1, 1, 1, 0, 8'h00, 8'h00, 8'h08);
    add(0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 1, 2, 1, 1, 0, 8'h00, 8'h00, 8'h08);
    add(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 1, 2, 1, 1, 0, 8'h00, 8'h00, 8'h08);
    add(0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 1, 1, 1, 1, 0, 8'h00, 8'h00, 8'h08);
    add(0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 2, 2, 1, 1, 0, 8'h00, 8'h00, 8'h08);
    add(0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 2, 1, 1, 1, 0, 8'h00, 8'h00, 8'h08);
    add(0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 3, 3, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    add(0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 3, 2, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    add(0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 3, 1, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    add(0, 1, 8'h00, 8'h00, 8'h00, 0, 0, 3, 0, 0, 0, 1, 8'h00, 8'h00, 8'h00);
    add(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 0, 8'h80, 8'h01, 8'h00, 0, 0, 3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);
    add(0, 0, 8'h00, 8'h00, 8'h00, 0, 0, 3, 0, 0, 0, 0, 8'h00, 8'h00, 8'h00);

    @(posedge clk);
    #1;
    foreach (vecs[i]) begin
      rst                = vecs[i].rst;
      bus.up_call        = vecs[i].up;
      bus.down_call      = vecs[i].dn;
      bus.car_call       = vecs[i].car;
      bus.door_open_btn  = vecs[i].obtn;
      bus.door_close_btn = vecs[i].cbtn;
      cyc(vecs[i].tick);
      check($sformatf("vec%0d", i), obs(), vecs[i].exp);
    end
    rst = 1'b0;

    // Stops at car call 2 then hall up 5, travelling up the whole way.
    do_reset();
    bus.up_call  = 8'h20;
    bus.car_call = 8'h04;
    cyc(1'b0);
    check("t2_latch", {bus.pend_up, bus.pend_car}, {8'h20, 8'h04});
    run_to_open(60, ok, sd);
    check("t2_open1_reached", ok, 1);
    check("t2_open1", {bus.floor, bus.dir_up, bus.pend_up, bus.pend_car}, {3'd2, 1'b1, 8'h20, 8'h00});
    run_to_closed(40, ok);
    check("t2_close1", ok, 1);
    run_to_open(60, ok, sd);
    check("t2_open2_reached", ok, 1);
    check("t2_open2", {bus.floor, bus.pend_up}, {3'd5, 8'h00});
    check("t2_dir_kept_up", sd, 0);

    // Down call at 4 latched while climbing past 2 toward 6.
    do_reset();
    bus.car_call = 8'h40;
    cyc(1'b0);
    run_to_floor(3'd2, 40, ok);
    check("t3_at2", ok, 1);
    bus.down_call = 8'h10;
    cyc(1'b0);
    check("t3_latch", bus.pend_down, 8'h10);
    run_to_open(60, ok, sd);
    check("t3_open6_reached", ok, 1);
    check("t3_open6", {bus.floor, bus.dir_up, bus.pend_down, bus.pend_car}, {3'd6, 1'b0, 8'h10, 8'h00});
    run_to_closed(40, ok);
    check("t3_close6", ok, 1);
    run_to_open(60, ok, sd);
    check("t3_open4_reached", ok, 1);
    check("t3_open4", {bus.floor, bus.pend_down}, {3'd4, 8'h00});

    // Door hold and early close at floor 3.
    do_reset();
    bus.car_call = 8'h08;
    cyc(1'b0);
    run_to_open(60, ok, sd);
    check("t4_open3", {ok, bus.floor, bus.countdown}, {1'b1, 3'd3, 2'd3});
    cyc(1'b1);
    check("t4_tick1", bus.countdown, 2'd2);
    bus.door_open_btn = 1'b1;
    cyc(1'b1);
    check("t4_hold", {bus.door_open, bus.countdown}, {1'b1, 2'd3});
    bus.door_open_btn  = 1'b1;
    bus.door_close_btn = 1'b1;
    cyc(1'b0);
    check("t4_both_btns", {bus.door_open, bus.countdown}, {1'b1, 2'd3});
    bus.door_close_btn = 1'b1;
    cyc(1'b0);
    check("t4_close", {bus.door_open, bus.countdown}, {1'b1, 2'd0});
    cyc(1'b0);
    check("t4_idle", {bus.door_open, bus.moving, bus.floor}, {1'b0, 1'b0, 3'd3});

    // Reset in the middle of a trip from 4 toward 5.
    do_reset();
    bus.car_call = 8'h80;
    cyc(1'b0);
    run_to_floor(3'd4, 40, ok);
    check("t6_at4", ok, 1);
    cyc(1'b1);
    check("t6_between", {bus.floor, bus.countdown, bus.moving}, {3'd4, 2'd1, 1'b1});
    rst = 1'b1;
    cyc(1'b1);
    rst = 1'b0;
    check("t6_reset", obs(), {3'd0, 2'd0, 1'b1, 1'b0, 1'b0, 8'h00, 8'h00, 8'h00});

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
